// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory (re/we/addr + tri-state data)
// among NREQ requesters; one word per grant, req/done handshake.
//
// state  | meaning
// IDLE   | no access in flight; pick winner from ptr upward with wrap
// ACCESS | drive memory controls for the latched winner (one cycle)
// DONE   | pulse done for the winner, advance ptr past it
module memory_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int AW   = 8
) (
   input  logic                 clock,
   input  logic                 reset_L,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ-1:0]      wr_i,
   input  logic [NREQ*AW-1:0]   addr_i,
   input  logic [NREQ*DW-1:0]   wdata_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic [DW-1:0]        rdata_o,
   output logic                 mem_re_o,
   output logic                 mem_we_o,
   output logic [AW-1:0]        mem_addr_o,
   inout  wire  [DW-1:0]        mem_data_io
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   w_q, w_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            drive;

   logic [PW-1:0]   win;
   logic            win_vld;
   logic [PW:0]     sum;
   logic [PW-1:0]   idx;
   logic            wr_sel;
   logic [AW-1:0]   addr_sel;
   logic [DW-1:0]   wdata_sel;

   // Scan from the highest offset down so the closest set bit to ptr wins last.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         idx = sum[PW-1:0];
         if (req_i[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      wr_sel    = 1'b0;
      addr_sel  = '0;
      wdata_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == PW'(i)) begin
            wr_sel    = wr_i[i];
            addr_sel  = addr_i[i*AW +: AW];
            wdata_sel = wdata_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      w_d        = w_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      gnt_o      = '0;
      done_o     = '0;
      mem_re_o   = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = '0;
      drive      = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               w_d     = win;
               wr_d    = wr_sel;
               addr_d  = addr_sel;
               wdata_d = wdata_sel;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            gnt_o      = NREQ'(1) << w_q;
            mem_addr_o = addr_q;
            if (wr_q) begin
               mem_we_o = 1'b1;
               drive    = 1'b1;
            end else begin
               mem_re_o = 1'b1;
               rdata_d  = mem_data_io;
            end
            state_d = DONE;
         end
         DONE: begin
            done_o  = NREQ'(1) << w_q;
            // explicit wrap keeps non-power-of-2 NREQ in range
            ptr_d   = (w_q == PW'(NREQ-1)) ? '0 : w_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_data_io = drive ? wdata_q : {DW{1'bz}};
   assign rdata_o     = rdata_q;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         w_q     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         w_q     <= w_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: reference model queues expected accesses, a monitor
// checks every cycle's outputs against them; directed and random phases.
module tb_memory_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int AW   = 8;

   logic                clock   = 1'b0;
   logic                reset_L = 1'b0;
   logic [NREQ-1:0]     req     = '0;
   logic [NREQ-1:0]     wr      = '0;
   logic [NREQ*AW-1:0]  addr    = '0;
   logic [NREQ*DW-1:0]  wdata   = '0;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     done;
   logic [DW-1:0]       rdata;
   logic                mem_re;
   logic                mem_we;
   logic [AW-1:0]       mem_addr;
   wire  [DW-1:0]       mem_data;

   memory_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clock       (clock),
      .reset_L     (reset_L),
      .req_i       (req),
      .wr_i        (wr),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .done_o      (done),
      .rdata_o     (rdata),
      .mem_re_o    (mem_re),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_data_io (mem_data)
   );

   always #5 clock = ~clock;

   // Memory instance: combinational read onto the bus, write at the clock edge.
   logic [DW-1:0] tb_mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) tb_mem[i] = '0;
   assign mem_data = mem_re ? tb_mem[mem_addr] : {DW{1'bz}};
   always @(posedge clock) if (mem_we) tb_mem[mem_addr] <= mem_data;

   typedef struct {
      int            w;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } acc_t;

   acc_t          q[$];
   acc_t          cur;
   acc_t          head;
   int            busy = 0;      // model cycles left in the current service (2,1,0)
   int            ptr  = 0;
   int            win;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_rdata = '0;
   int            n_cmp = 0;
   int            n_err = 0;
   int            prob  = 0;
   logic [NREQ-1:0] last_done = '0;
   logic [NREQ-1:0] e_gnt, e_done;
   logic            e_re, e_we;
   logic [AW-1:0]   e_addr;

   initial for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one access per three cycles, winner = first request from ptr with wrap.
   initial forever begin
      @(posedge clock or negedge reset_L);
      if (!reset_L) begin
         busy = 0;
         ptr  = 0;
         q.delete();
      end else if (busy == 2) begin
         if (cur.wr) ref_mem[cur.addr] = cur.data;
         busy = 1;
      end else if (busy == 1) begin
         ptr  = (cur.w + 1) % NREQ;
         busy = 0;
      end else if (req != '0) begin
         win = -1;
         for (int k = 0; k < NREQ; k++)
            if (win < 0 && req[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
         cur.w    = win;
         cur.wr   = wr[win];
         cur.addr = addr[win*AW +: AW];
         cur.data = wdata[win*DW +: DW];
         q.push_back(cur);
         busy = 2;
      end
   end

   // Monitor: compares the DUT outputs with the queued expectation every cycle.
   initial forever begin
      @(negedge clock);
      if (!reset_L) exp_rdata = '0;
      e_gnt  = '0;
      e_done = '0;
      e_re   = 1'b0;
      e_we   = 1'b0;
      e_addr = '0;
      if (busy != 0 && q.size() == 0) begin
         check("sb_underflow", 64'(q.size()), 64'(1));
      end else if (busy != 0) begin
         head = q[0];
         if (busy == 2) begin
            e_gnt  = NREQ'(1) << head.w;
            e_re   = !head.wr;
            e_we   = head.wr;
            e_addr = head.addr;
            if (head.wr) check("bus_wdata", 64'(mem_data), 64'(head.data));
         end else begin
            e_done = NREQ'(1) << head.w;
            void'(q.pop_front());
            if (!head.wr) exp_rdata = ref_mem[head.addr];
         end
      end
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("done", 64'(done), 64'(e_done));
      check("mem_re", 64'(mem_re), 64'(e_re));
      check("mem_we", 64'(mem_we), 64'(e_we));
      check("mem_addr", 64'(mem_addr), 64'(e_addr));
      check("re_we_excl", 64'(mem_re & mem_we), 64'(0));
      check("rdata", 64'(rdata), 64'(exp_rdata));
   end

   // One cycle of requester behaviour: drop on done, optionally raise a new random request.
   task automatic step();
      @(negedge clock);
      last_done = done;
      for (int i = 0; i < NREQ; i++) begin
         if (done[i]) req[i] = 1'b0;
         else if (!req[i] && prob > 0 && $urandom_range(99) < 32'(prob)) begin
            req[i] = 1'b1;
            wr[i]  = 1'($urandom_range(1));
            addr[i*AW +: AW]  = AW'($urandom_range(15));
            wdata[i*DW +: DW] = DW'($urandom);
         end
      end
   endtask

   task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1;
      wr[i]  = w;
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic wait_done(input int i, output int lat);
      bit seen = 1'b0;
      lat = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         lat++;
         if (last_done[i]) seen = 1'b1;
      end
      if (!seen) begin
         check("timeout_done", 64'(0), 64'(1));
         lat = -1;
      end
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int c = 0; c < 300 && !ok; c++) begin
         step();
         if (req == '0 && busy == 0) ok = 1'b1;
      end
      check("drain", 64'(ok), 64'(1));
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic collect(input int n, output int ord[$]);
      ord.delete();
      for (int c = 0; c < 40*n && ord.size() < n; c++) begin
         step();
         if (last_done != '0) ord.push_back(idx_of(last_done));
      end
      if (ord.size() < n) check("timeout_collect", 64'(ord.size()), 64'(n));
   endtask

   int lat;
   int ord[$];

   initial begin
      // reset state
      repeat (2) @(negedge clock);
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_re_we", 64'({mem_re, mem_we}), 64'(0));
      check("rst_addr", 64'(mem_addr), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      #2 reset_L = 1'b1;

      // contention 1010 with ptr at 0
      step();
      issue(1, 1'b0, 8'h01, 16'h0000);
      issue(3, 1'b1, 8'h03, 16'h3333);
      collect(2, ord);
      if (ord.size() == 2) begin
         check("cont_first", 64'(ord[0]), 64'(1));
         check("cont_second", 64'(ord[1]), 64'(3));
      end

      // fairness: everyone keeps requesting; pointer must start from 0
      prob = 100;
      collect(12, ord);
      prob = 0;
      for (int k = 0; k < ord.size(); k++) check("fair_order", 64'(ord[k]), 64'(k % NREQ));
      drain();

      // write then read with latency
      step();
      issue(0, 1'b1, 8'h10, 16'hBEEF);
      wait_done(0, lat);
      check("wr_latency", 64'(lat), 64'(2));
      step();
      issue(0, 1'b0, 8'h10, 16'h0000);
      wait_done(0, lat);
      check("rd_latency", 64'(lat), 64'(2));
      check("rd_beef", 64'(rdata), 64'(16'hBEEF));

      // random traffic
      prob = 30;
      repeat (1000) step();
      prob = 0;
      drain();

      // reset during the ACCESS cycle of a write
      step();
      issue(2, 1'b1, 8'h20, 16'h0000);
      wait_done(2, lat);
      step();
      issue(1, 1'b1, 8'h20, 16'h1234);
      step();
      check("mid_gnt", 64'(gnt), 64'(4'b0010));
      check("mid_we", 64'(mem_we), 64'(1));
      #2 reset_L = 1'b0;
      #1;
      check("mid_rst_gnt", 64'(gnt), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      check("mid_rst_re_we", 64'({mem_re, mem_we}), 64'(0));
      check("mid_rst_addr", 64'(mem_addr), 64'(0));
      check("mid_rst_rdata", 64'(rdata), 64'(0));
      req = '0;
      step();
      #2 reset_L = 1'b1;
      step();
      issue(0, 1'b0, 8'h20, 16'h0000);
      for (int i = 1; i < NREQ; i++) issue(i, 1'b0, AW'($urandom_range(15)), 16'h0000);
      collect(1, ord);
      if (ord.size() == 1) begin
         check("post_rst_winner", 64'(ord[0]), 64'(0));
         check("post_rst_read", 64'(rdata), 64'(16'h0000));
      end
      drain();

      // idle: nothing moves, rdata holds
      repeat (20) step();
      check("idle_gnt_done", 64'({gnt, done}), 64'(0));
      check("idle_re_we", 64'({mem_re, mem_we}), 64'(0));
      check("idle_rdata", 64'(rdata), 64'(exp_rdata));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port Memory (re/we/addr plus a bidirectional tri-state data bus) among NREQ requesters.
- Each requester issues a one-word read or write with a req/done handshake.
- The arbiter owns every Memory control line and is the only driver of the shared data bus during writes.
- It sits between the game-logic clients (sprite/tile fetch, score update) and the Memory instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, memory data width; must match the Memory instance.
- AW, 8, memory address width; must match the Memory instance.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request; bit i belongs to requester i.
- wr  input  NREQ  per-requester op select; 1 = write, 0 = read. Sampled with req.
- addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- gnt  output  NREQ  one-hot; high for the requester currently being served.
- done  output  NREQ  one-hot, one-cycle pulse when requester i's access completes.
- rdata  output  DW  registered read data; valid in the done cycle, held until the next read completes.
- mem_re  output  1  Memory read enable.
- mem_we  output  1  Memory write enable.
- mem_addr  output  AW  Memory address.
- mem_data  inout  DW  Memory data bus (tri).

Behaviour:
- Reset (asynchronous, reset_L=0):
  - State = IDLE, round-robin pointer ptr = 0.
  - gnt, done, mem_re, mem_we = 0; mem_addr = 0; rdata = 0; mem_data released to high-Z.
  - An access in progress is abandoned. mem_we drops before the next edge, so no write commits.
- States: IDLE, ACCESS, DONE. Encoding is free.
- IDLE:
  - If req == 0, stay in IDLE; all outputs are 0.
  - Otherwise pick winner w = the first set req bit scanning upward from ptr with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - Register w plus its wr, addr and wdata, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt[w] = 1; mem_addr = registered addr.
  - Read: mem_re = 1, mem_we = 0; mem_data is not driven. At the closing edge, rdata <= mem_data.
  - Write: mem_we = 1, mem_re = 0; mem_data is driven with registered wdata. The Memory commits at the closing edge.
  - Always go to DONE.
- DONE (1 cycle):
  - done[w] = 1; gnt = 0; mem_re = mem_we = 0; mem_data is high-Z.
  - ptr <= (w+1) mod NREQ. Go to IDLE.
- Latency: req rising in cycle 0 (IDLE) → ACCESS in cycle 1 → done in cycle 2. Peak throughput is 1 access per 3 cycles.
- Requester rules:
  - Hold req, wr, addr and wdata stable from assertion until done.
  - Drop req in the cycle after done. If req is still high when the arbiter returns to IDLE, it is treated as a new request.
  - Fairness: with all requesters asserting continuously, service order is 0,1,2,...,NREQ-1,0,...
- Bus safety:
  - mem_re and mem_we are never both 1.
  - mem_data is driven only in a write ACCESS cycle and is high-Z in every other state, including reset.
- Simultaneous events:
  - A new req arriving during ACCESS or DONE waits for IDLE.
  - Requests that arrive together are resolved purely by ptr.
  - A req dropped mid-access does not abort it; done still pulses.
- Widths: ptr is $clog2(NREQ) bits. The wrap is explicit, so it is correct for non-power-of-2 NREQ.

Test Plan:
- Write then read: requester 0 writes 16'hBEEF to addr 8'h10 (req in cycle 0), then reads 8'h10 → mem_we=1 in cycle 1 only, done[0] in cycle 2; read returns rdata=16'hBEEF with done[0] 2 cycles after req.
- Contention: req=4'b1010 in IDLE with ptr=0 → requester 1 is served first, done[1] pulses, then requester 3, then the pointer sits at 0.
- Fairness: all 4 requesters hold req high for 12 accesses → gnt order is 0,1,2,3,0,1,2,3,0,1,2,3; no requester starves.
- Bus safety: random reads and writes for 1000 cycles → mem_re & mem_we is never 1; mem_data is Z whenever not (ACCESS & write); no X on the bus.
- Reset mid-write: assert reset_L=0 during the ACCESS cycle of a write of 16'h1234 to addr 8'h20 (previously 16'h0000) → all outputs 0 immediately, a later read of 8'h20 returns 16'h0000, and ptr=0 so requester 0 wins the next contention.
- Idle: req=0 for 20 cycles → gnt, done, mem_re and mem_we stay 0, and rdata holds its last value.
